phase_timer_sel: RTL and testbench

PHASE_TIMER_SEL -- requirements
Module: phase_timer_sel

---
 rtl/phase_timer_sel.sv | 131 +++++++++++++
 tb/tb_phase_timer_sel.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer_sel.sv
// phase_timer_sel
//   Selects one of NCH timing values through a writable state-to-channel map
//   and runs a loadable countdown timer from the selected value.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   state     : present controller state code, indexes the map
//   t_in      : packed timing values, channel k = t_in[k*WIDTH +: WIDTH]
//   map_we    : map write strobe
//   map_addr  : map entry to write
//   map_data  : channel index to store (clamped to NCH-1)
//   start     : load the selected value and start counting
//   hold      : freeze the countdown while high
//   tout      : registered selected timing value
//   ch_sel    : registered channel index behind tout
//   count     : current countdown value
//   busy      : high while counting
//   done      : one-cycle pulse when the countdown expires
module phase_timer_sel #(
  parameter  int WIDTH = 13,
  parameter  int NCH   = 4,
  parameter  int SW    = 4,
  localparam int CW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW-1:0]        state,
  input  logic [NCH*WIDTH-1:0] t_in,
  input  logic                 map_we,
  input  logic [SW-1:0]        map_addr,
  input  logic [CW-1:0]        map_data,
  input  logic                 start,
  input  logic                 hold,
  output logic [WIDTH-1:0]     tout,
  output logic [CW-1:0]        ch_sel,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEPTH = 2**SW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tout_q;
  logic [CW-1:0]    ch_q;
  logic [CW-1:0]    map_q [DEPTH];
  logic [CW-1:0]    sel_ch;
  logic [CW-1:0]    map_wdata;
  logic [WIDTH-1:0] sel_val;

  // Legacy two-channel layout: entries 0, 3 and 4 use channel 0, all others channel 1.
  function automatic logic [CW-1:0] map_default(input int unsigned idx);
    return (idx == 0 || idx == 3 || idx == 4) ? '0 : CW'(1);
  endfunction

  // Read of the map sees the pre-write contents in a write cycle.
  assign sel_ch = map_q[state];

  always_comb begin
    sel_val = '0;
    for (int unsigned k = 0; k < 32'(NCH); k++) begin
      if (sel_ch == CW'(k)) sel_val = t_in[k*WIDTH +: WIDTH];
    end
  end

  assign map_wdata = (32'(map_data) >= 32'(NCH)) ? CW'(NCH - 1) : map_data;

  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start) begin
          count_d = sel_val;
          fsm_d   = (sel_val != '0) ? RUN : DONE;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        // Restart outranks hold and decrement.
        if (start) begin
          count_d = sel_val;
          fsm_d   = (sel_val != '0) ? RUN : DONE;
        end else if (!hold) begin
          if (count_q <= WIDTH'(1)) begin
            count_d = '0;
            fsm_d   = DONE;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: begin
        fsm_d   = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      count_q <= '0;
      tout_q  <= '0;
      ch_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) map_q[i] <= map_default(i);
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      tout_q  <= sel_val;
      ch_q    <= sel_ch;
      if (map_we) map_q[map_addr] <= map_wdata;
    end
  end

  assign tout   = tout_q;
  assign ch_sel = ch_q;
  assign count  = count_q;
  assign busy   = (fsm_q == RUN);
  assign done   = (fsm_q == DONE);

endmodule

// File: tb/tb_phase_timer_sel.sv
// Testbench for phase_timer_sel: a driver pushes per-cycle expectations from a
// behavioural model into a queue; a monitor pops and compares after each edge.
module tb_phase_timer_sel;

  localparam int WIDTH = 13;
  localparam int NCH   = 4;
  localparam int SW    = 4;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [SW-1:0]        state = '0;
  logic [NCH*WIDTH-1:0] t_in = '0;
  logic                 map_we = 1'b0;
  logic [SW-1:0]        map_addr = '0;
  logic [CW-1:0]        map_data = '0;
  logic                 start = 1'b0;
  logic                 hold = 1'b0;
  logic [WIDTH-1:0]     tout;
  logic [CW-1:0]        ch_sel;
  logic [WIDTH-1:0]     count;
  logic                 busy;
  logic                 done;

  phase_timer_sel #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .t_in(t_in),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .start(start), .hold(hold), .tout(tout), .ch_sel(ch_sel),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tout; int ch; int count; int busy; int done;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model
  int m_map [16];
  int m_count, m_tout, m_ch;
  bit m_run, m_pulse;
  logic [NCH*WIDTH-1:0] tin_next = '0;

  function automatic int chan(input int k);
    return int'(tin_next[k*WIDTH +: WIDTH]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_map[i] = (i == 0 || i == 3 || i == 4) ? 0 : 1;
    m_count = 0; m_tout = 0; m_ch = 0; m_run = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit rst, input int st, input bit st_go, input bit hd,
                            input bit we, input int addr, input int data);
    int sel, val;
    if (!rst) begin
      model_reset();
      return;
    end
    sel = m_map[st];
    val = chan(sel);
    m_tout = val;
    m_ch   = sel;
    if (st_go) begin
      m_count = val;
      m_run   = (val != 0);
      m_pulse = (val == 0);
    end else if (m_run) begin
      m_pulse = 0;
      if (!hd) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_run = 0;
          m_pulse = 1;
        end
      end
    end else begin
      m_pulse = 0;
    end
    if (we) m_map[addr] = (data > NCH - 1) ? NCH - 1 : data;
  endtask

  // Samples of DUT outputs taken at the falling edge
  int s_count;
  bit s_busy, s_done;

  task automatic sample_edge();
    @(negedge clk);
    s_count = int'(count);
    s_busy  = busy;
    s_done  = done;
  endtask

  task automatic drive(input bit rst, input int st, input bit st_go, input bit hd,
                       input bit we, input int addr, input int data);
    exp_t e;
    rst_n    = rst;
    state    = 4'(st);
    start    = st_go;
    hold     = hd;
    map_we   = we;
    map_addr = 4'(addr);
    map_data = 2'(data);
    t_in     = tin_next;
    model_step(rst, st, st_go, hd, we, addr, data);
    e.tout = m_tout; e.ch = m_ch; e.count = m_count;
    e.busy = int'(m_run); e.done = int'(m_pulse);
    q.push_back(e);
    if (!rst) begin
      #1;
      check("rst_now_count", 32'(count), 0);
      check("rst_now_tout",  32'(tout), 0);
      check("rst_now_ch",    32'(ch_sel), 0);
      check("rst_now_busy",  32'(busy), 0);
      check("rst_now_done",  32'(done), 0);
    end
  endtask

  task automatic tick(input int st, input bit st_go, input bit hd);
    sample_edge();
    drive(1'b1, st, st_go, hd, 1'b0, 0, 0);
  endtask

  task automatic wr_map(input int addr, input int data);
    sample_edge();
    drive(1'b1, 0, 1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic set_ch(input int k, input int v);
    tin_next[k*WIDTH +: WIDTH] = 13'(v);
  endtask

  // Monitor: compare DUT against the oldest expectation one step after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("tout",   32'(tout),   32'(e.tout));
        check("ch_sel", 32'(ch_sel), 32'(e.ch));
        check("count",  32'(count),  32'(e.count));
        check("busy",   32'(busy),   32'(e.busy));
        check("done",   32'(done),   32'(e.done));
      end
    end
  end

  task automatic measure(input bit use_hold, output int n);
    bit seen = 0;
    n = 0;
    tick(6, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      sample_edge();
      n++;
      if (s_done) begin
        seen = 1;
        drive(1'b1, 6, 1'b0, 1'b0, 1'b0, 0, 0);
        break;
      end
      drive(1'b1, 6, 1'b0, use_hold && i >= 3 && i < 6, 1'b0, 0, 0);
    end
    check("measure_done_seen", 32'(seen), 1);
  endtask

  initial begin
    int busy_n, done_n, n0, n1, lim;
    bit reached;
    model_reset();

    // Reset held for two cycles, then released
    sample_edge(); drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    sample_edge(); drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    set_ch(0, 100); set_ch(1, 200); set_ch(2, 7); set_ch(3, 50);
    tick(0, 1'b0, 1'b0);

    // Default map sweep
    for (int s = 0; s < 16; s++) tick(s, 1'b0, 1'b0);

    // map[5]=2, channel 2 = 7: seven busy cycles and one done pulse
    wr_map(5, 2);
    tick(5, 1'b1, 1'b0);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(5, 1'b0, 1'b0);
      busy_n += int'(s_busy);
      done_n += int'(s_done);
    end
    check("run7_busy_cycles", 32'(busy_n), 7);
    check("run7_done_pulses", 32'(done_n), 1);

    // Zero selection: straight to done
    wr_map(6, 3);
    set_ch(3, 0);
    tick(6, 1'b1, 1'b0);
    tick(6, 1'b0, 1'b0);
    check("zero_busy", 32'(s_busy), 0);
    check("zero_done", 32'(s_done), 1);
    tick(6, 1'b0, 1'b0);

    // Countdown from 10, without and with 3 hold cycles
    set_ch(3, 10);
    tick(6, 1'b0, 1'b0);
    measure(1'b0, n0);
    tick(6, 1'b0, 1'b0);
    measure(1'b1, n1);
    check("nohold_latency", 32'(n0), 11);
    check("hold_extra_cycles", 32'(n1 - n0), 3);
    tick(6, 1'b0, 1'b0);

    // Restart at count 4 with selection 9, then reset at count 5
    set_ch(2, 9);
    tick(6, 1'b1, 1'b0);
    reached = 0;
    for (int i = 0; i < 30; i++) begin
      sample_edge();
      if (s_count == 4 && s_busy) begin
        reached = 1;
        drive(1'b1, 5, 1'b1, 1'b0, 1'b0, 0, 0);
        break;
      end
      drive(1'b1, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    check("restart_reached4", 32'(reached), 1);
    tick(5, 1'b0, 1'b0);
    check("restart_count9", 32'(s_count), 9);
    check("restart_no_done", 32'(s_done), 0);
    reached = 0;
    for (int i = 0; i < 30; i++) begin
      sample_edge();
      if (s_count == 5) begin
        reached = 1;
        drive(1'b0, 5, 1'b0, 1'b0, 1'b0, 0, 0);
        break;
      end
      drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    check("reset_at5_reached", 32'(reached), 1);
    sample_edge(); drive(1'b0, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    set_ch(0, 100); set_ch(1, 200);
    // After release: no done pulse, idle, map back to defaults
    for (int s = 0; s < 16; s++) begin
      tick(s, 1'b0, 1'b0);
      if (s > 0) check("post_reset_no_done", 32'(s_done), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) set_ch($urandom_range(0, 3), $urandom_range(0, 15));
      sample_edge();
      lim = $urandom_range(0, 199);
      drive(lim != 0, $urandom_range(0, 15), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15), $urandom_range(0, 3));
    end

    tick(0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
